// File: rtl/register_file.sv
// 32-entry, 2-read/1-write register file with a post-reset clear sweep.
// Reads are combinational with write-through bypass; writes and status take one edge.
// Ready is low during the clear sweep; writes offered while not Ready are dropped.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Ready,
  output logic                  WriteAck,
  output logic [7:0]            WriteCount
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = '0;
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
  logic                  write_ack_q, write_ack_d;
  logic [7:0]            write_count_q, write_count_d;

  // Register 0 is never written (sweep starts at 1, index-0 writes are
  // rejected); its read value is forced to zero at the read ports instead.
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  logic                  run;
  logic                  accept;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign run    = (state_q == ST_RUN);
  assign accept = run && RegWrite && (WriteRegister != ZERO_IDX);

  // Next-state: the sweep owns the write port in INIT, the user owns it in RUN.
  always_comb begin
    state_d       = state_q;
    sweep_idx_d   = sweep_idx_q;
    write_ack_d   = accept;
    write_count_d = write_count_q;
    mem_we        = 1'b0;
    mem_waddr     = WriteRegister;
    mem_wdata     = WriteData;
    if (state_q == ST_INIT) begin
      mem_we      = 1'b1;
      mem_waddr   = sweep_idx_q;
      mem_wdata   = '0;
      sweep_idx_d = sweep_idx_q + FIRST_IDX;
      if (sweep_idx_q == LAST_IDX) begin
        state_d = ST_RUN;
      end
    end else if (accept) begin
      mem_we        = 1'b1;
      write_count_d = write_count_q + 8'd1;
    end
  end

  // Control and status flops; reset restarts the sweep and clears status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      sweep_idx_q   <= FIRST_IDX;
      write_ack_q   <= 1'b0;
      write_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      write_ack_q   <= write_ack_d;
      write_count_q <= write_count_d;
    end
  end

  // Storage array: no reset of its own, and a reset edge blocks any write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read port 1: zero for index 0 or during the sweep, else bypass or array.
  always_comb begin
    ReadData1 = '0;
    if (run && (ReadRegister1 != ZERO_IDX)) begin
      if (accept && (WriteRegister == ReadRegister1)) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = mem_q[ReadRegister1];
      end
    end
  end

  // Read port 2: identical rule to port 1, independent index.
  always_comb begin
    ReadData2 = '0;
    if (run && (ReadRegister2 != ZERO_IDX)) begin
      if (accept && (WriteRegister == ReadRegister2)) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = mem_q[ReadRegister2];
      end
    end
  end

  assign Ready      = run;
  assign WriteAck   = write_ack_q;
  assign WriteCount = write_count_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file.
// Stimulus pushes the expected per-cycle outputs; a negedge monitor pops and compares.
// The reference model tracks edges since reset and a plain array of register values.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Ready;
  logic        WriteAck;
  logic [7:0]  WriteCount;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .Ready         (Ready),
    .WriteAck      (WriteAck),
    .WriteCount    (WriteCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ready;
    logic        ack;
    logic [7:0]  cnt;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          have_state = 0;
  int          edges_since_reset = 0;
  bit          m_ack = 0;
  int          m_cnt = 0;
  logic [31:0] m_mem [32];

  function automatic logic [31:0] model_read(input logic [4:0] ra, input bit rdy,
                                             input bit acc, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (!rdy || ra == 5'd0) return 32'd0;
    if (acc && wa == ra) return wd;
    return m_mem[ra];
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance model at the edge.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    bit   rdy;
    bit   acc;
    exp_t e;
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2;
    rdy = (edges_since_reset >= 31);
    acc = rdy && we && (wa != 5'd0);
    if (have_state) begin
      e.ready = rdy;
      e.ack   = m_ack;
      e.cnt   = m_cnt[7:0];
      e.rd1   = model_read(r1, rdy, acc, wa, wd);
      e.rd2   = model_read(r2, rdy, acc, wa, wd);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      have_state        = 1;
      edges_since_reset = 0;
      m_ack             = 0;
      m_cnt             = 0;
    end else if (have_state) begin
      if (!rdy) begin
        edges_since_reset++;
        if (edges_since_reset == 31) begin
          for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        end
        m_ack = 0;
      end else begin
        if (acc) begin
          m_mem[wa] = wd;
          m_cnt     = (m_cnt + 1) % 256;
        end
        m_ack = acc;
      end
    end
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one expectation per sampled cycle, compared away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ready",      {31'd0, Ready},    {31'd0, e.ready});
      check("write_ack",  {31'd0, WriteAck}, {31'd0, e.ack});
      check("write_cnt",  {24'd0, WriteCount}, {24'd0, e.cnt});
      check("read_data1", ReadData1, e.rd1);
      check("read_data2", ReadData2, e.rd2);
    end
  end

  function automatic logic [4:0] rnd_addr();
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [4:0] a;
    int         ready_edge;
    // Two reset cycles, then the sweep; writes offered during INIT must vanish
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 5'd3, 32'h1111_1111, 5'd3, 5'd0);
    ready_edge = -1;
    for (int i = 0; i < 36; i++) begin
      if (Ready && ready_edge < 0) ready_edge = i;
      step(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, rnd_addr(), rnd_addr());
    end
    check("ready_after_31_edges", 32'(ready_edge), 32'd31);
    for (int i = 1; i < 32; i++) step(0, 0, 0, 0, 5'(i), 5'(32 - i));

    // Write then read back on both ports
    step(0, 1, 5'd6, 32'hDEAD_BEEF, 5'd1, 5'd2);
    step(0, 0, 0, 0, 5'd6, 5'd6);
    // Same-cycle bypass
    step(0, 1, 5'd4, 32'h1234_5678, 5'd4, 5'd6);
    step(0, 0, 0, 0, 5'd4, 5'd4);
    // Index 0 writes are discarded
    step(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(0, 0, 0, 0, 5'd0, 5'd6);

    // 256 back-to-back accepted writes: count wraps, ack stays high
    for (int i = 0; i < 256; i++) begin
      a = 5'($urandom_range(1, 31));
      step(0, 1, a, $urandom, a, rnd_addr());
    end
    step(0, 0, 0, 0, rnd_addr(), rnd_addr());

    // Reset mid-run with a write pending: write lost, reg 9 swept to 0
    step(0, 1, 5'd9, 32'hA5A5_A5A5, 5'd0, 5'd0);
    step(0, 0, 0, 0, 5'd9, 5'd9);
    step(1, 1, 5'd9, 32'h5A5A_5A5A, 5'd9, 5'd0);
    for (int i = 0; i < 34; i++) step(0, 1'($urandom_range(0, 1)), 5'd9, $urandom, 5'd9, rnd_addr());

    // Reset in the middle of a sweep
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, rnd_addr(), rnd_addr());
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 33; i++) step(0, 0, 0, 0, rnd_addr(), rnd_addr());

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           rnd_addr(), $urandom, rnd_addr(), rnd_addr());
    end
    step(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
